mmcm_phase_sweep: RTL and testbench
===================================

// Module: mmcm_phase_sweep
// PURPOSE
//  Sequences the MMCM phase-shift stepper through a linear sweep of absolute phase targets.
//  For each point it programs the stepper target, waits for the stepper to settle, and then holds for a dwell window.
//  It marks the start of each dwell so downstream glitch/capture logic can act at a known phase.
//  Sits between the host register file and the MMCM phase-shift stepper (target/configure/configured handshake).
// PARAMETERS
//  PHASE_WIDTH    32     width of phase target / step (signed, in MMCM fine-shift steps)
//  COUNT_WIDTH    16     width of point count / point index
//  DWELL_WIDTH    16     width of dwell cycle count
//  TIMEOUT_CYCLES 65535  max cycles waiting on stepper per point before error
// PORTS
//  clk            in   1            system clock
//  rst            in   1            asynchronous reset, active-high
//  start          in   1            pulse: latch sweep config, begin sweep (ignored while busy)
//  abort          in   1            pulse: stop sweep, return to IDLE
//  start_phase    in   PHASE_WIDTH  signed first target
//  step           in   PHASE_WIDTH  signed increment between points
//  num_points     in   COUNT_WIDTH  number of points in sweep (0 = empty sweep)
//  dwell_cycles   in   DWELL_WIDTH  cycles to hold each settled point
//  return_home    in   1            1: after last point, re-target start_phase before done
//  busy           out  1            high from accepted start until done/abort
//  done           out  1            1-cycle pulse at sweep completion
//  error          out  1            sticky stepper timeout flag, cleared by accepted start
//  point_valid    out  1            1-cycle pulse on first cycle of each dwell
//  point_index    out  COUNT_WIDTH  index of current point (0-based)
//  ps_target      out  PHASE_WIDTH  absolute target to stepper
//  ps_configure   out  1            1-cycle pulse to stepper
//  ps_configured  in   1            stepper idle/settled level (drops >=1 cycle after configure)
// BEHAVIOUR
//  Reset: all outputs 0 and state IDLE; latched config 0. All outputs are registered.
//  States: IDLE, REQ, WAIT_LOW, WAIT_HIGH, DWELL, NEXT, HOME_REQ, HOME_WAIT_LOW, HOME_WAIT_HIGH, DONE.
//  IDLE: start=1 -> latch inputs, busy=1, error=0, point_index=0, ps_target=start_phase.
//   Next state is REQ, or DONE if num_points==0.
//  REQ: when ps_configured=1 -> ps_configure=1 for 1 cycle, go to WAIT_LOW. Never pulse configure while ps_configured=0.
//  WAIT_LOW: ps_configured=0 -> WAIT_HIGH. Configured-high before the drop is NOT treated as settled.
//  WAIT_HIGH: ps_configured=1 -> DWELL, point_valid=1 this edge, dwell counter loaded.
//  DWELL: hold for exactly max(dwell_cycles,1) cycles including the point_valid cycle, then NEXT.
//  NEXT: if point_index==num_points-1 -> HOME_REQ when return_home, else DONE.
//   Otherwise ps_target+=step, point_index+=1, go to REQ.
//  Target arithmetic: two's complement, wraps mod 2^PHASE_WIDTH. No saturation.
//  HOME_*: same handshake as REQ/WAIT_*, with ps_target=start_phase. No point_valid.
//  DONE: done=1 for 1 cycle, busy=0, go to IDLE. ps_target holds last value.
//  Timeout: counter runs in REQ and in the WAIT_LOW/WAIT_HIGH (and HOME_) states, and resets at each state entry.
//   Reaching TIMEOUT_CYCLES -> error=1, busy=0, IDLE, no done.
//  abort: has priority over all transitions except reset. Next cycle state=IDLE, busy=0.
//   No done pulse. ps_target holds. The stepper finishes its move autonomously.
//  start while busy: ignored. start and abort in the same IDLE cycle: abort wins, start dropped.
//  Restart after abort: REQ waits for ps_configured=1, so an in-flight stepper move is never interrupted.
//  Async reset mid-sweep: immediate return to reset values. The stepper is not reset by this block.
// TESTING
//  start_phase=100, step=5, num_points=3, dwell=4, stepper model 10-cycle settle
//   -> ps_target 100,105,110. Three point_valid pulses, 4 cycles apart from settle. done once. busy low after.
//  step=-1, start_phase=0x7FFFFFFF->0x80000001 wrap check
//   -> targets 0x7FFFFFFF,0x7FFFFFFE; separately step=+2 from 0x7FFFFFFF -> 0x80000001.
//  num_points=0 -> no ps_configure. done 2 cycles after start. point_valid never asserted.
//  return_home=1, 2 points from 40 step 8 -> targets 40,48,40. Only 2 point_valid. done after home settle.
//  abort during WAIT_HIGH, then start immediately while stepper configured=0
//   -> no done. The new ps_configure only after configured returns high.
//  Stepper model never drops configured, TIMEOUT_CYCLES=16 -> error=1 after 16 cycles in WAIT_LOW.
//   busy=0. Next accepted start clears error.

Source files
------------

// File: rtl/mmcm_phase_sweep.sv
// Steps an MMCM phase-shift stepper through a linear sweep of absolute targets,
// waiting for each move to settle and dwelling a programmable time per point.
module mmcm_phase_sweep #(
  parameter int PHASE_WIDTH    = 32,
  parameter int COUNT_WIDTH    = 16,
  parameter int DWELL_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [PHASE_WIDTH-1:0] start_phase,
  input  logic [PHASE_WIDTH-1:0] step,
  input  logic [COUNT_WIDTH-1:0] num_points,
  input  logic [DWELL_WIDTH-1:0] dwell_cycles,
  input  logic                   return_home,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic                   point_valid,
  output logic [COUNT_WIDTH-1:0] point_index,
  output logic [PHASE_WIDTH-1:0] ps_target,
  output logic                   ps_configure,
  input  logic                   ps_configured
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    IDLE,
    REQ,
    WAIT_LOW,
    WAIT_HIGH,
    DWELL,
    NEXT,
    HOME_REQ,
    HOME_WAIT_LOW,
    HOME_WAIT_HIGH,
    DONE
  } state_t;

  state_t                 state;
  logic [PHASE_WIDTH-1:0] start_phase_reg;
  logic [PHASE_WIDTH-1:0] step_reg;
  logic [COUNT_WIDTH-1:0] num_points_reg;
  logic [DWELL_WIDTH-1:0] dwell_reg;
  logic                   return_home_reg;
  logic [DWELL_WIDTH-1:0] dwell_cnt;
  logic [TW-1:0]          timer;

  logic waiting;
  logic advance;
  logic timer_expired;

  // Handshake states wait on the stepper; 'advance' is the exit condition of each.
  always_comb begin
    waiting = 1'b0;
    advance = 1'b0;
    case (state)
      REQ, HOME_REQ: begin
        waiting = 1'b1;
        advance = ps_configured;
      end
      WAIT_LOW, HOME_WAIT_LOW: begin
        waiting = 1'b1;
        advance = ~ps_configured;
      end
      WAIT_HIGH, HOME_WAIT_HIGH: begin
        waiting = 1'b1;
        advance = ps_configured;
      end
      default: begin
        waiting = 1'b0;
        advance = 1'b0;
      end
    endcase
  end

  assign timer_expired = (timer == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      start_phase_reg <= '0;
      step_reg        <= '0;
      num_points_reg  <= '0;
      dwell_reg       <= '0;
      return_home_reg <= 1'b0;
      dwell_cnt       <= '0;
      timer           <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
      point_valid     <= 1'b0;
      point_index     <= '0;
      ps_target       <= '0;
      ps_configure    <= 1'b0;
    end else begin
      done         <= 1'b0;
      point_valid  <= 1'b0;
      ps_configure <= 1'b0;

      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else if (waiting && !advance) begin
        if (timer_expired) begin
          error <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end else begin
          timer <= timer + 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              start_phase_reg <= start_phase;
              step_reg        <= step;
              num_points_reg  <= num_points;
              dwell_reg       <= dwell_cycles;
              return_home_reg <= return_home;
              busy            <= 1'b1;
              error           <= 1'b0;
              point_index     <= '0;
              ps_target       <= start_phase;
              timer           <= '0;
              state           <= (num_points == '0) ? DONE : REQ;
            end
          end
          REQ: begin
            ps_configure <= 1'b1;
            timer        <= '0;
            state        <= WAIT_LOW;
          end
          WAIT_LOW: begin
            timer <= '0;
            state <= WAIT_HIGH;
          end
          WAIT_HIGH: begin
            point_valid <= 1'b1;
            // Counter holds remaining cycles after this one; zero dwell still gets one cycle.
            dwell_cnt   <= (dwell_reg == '0) ? '0 : dwell_reg - 1'b1;
            state       <= DWELL;
          end
          DWELL: begin
            if (dwell_cnt == '0) begin
              state <= NEXT;
            end else begin
              dwell_cnt <= dwell_cnt - 1'b1;
            end
          end
          NEXT: begin
            timer <= '0;
            if (point_index == num_points_reg - 1'b1) begin
              if (return_home_reg) begin
                ps_target <= start_phase_reg;
                state     <= HOME_REQ;
              end else begin
                state <= DONE;
              end
            end else begin
              ps_target   <= ps_target + step_reg;
              point_index <= point_index + 1'b1;
              state       <= REQ;
            end
          end
          HOME_REQ: begin
            ps_configure <= 1'b1;
            timer        <= '0;
            state        <= HOME_WAIT_LOW;
          end
          HOME_WAIT_LOW: begin
            timer <= '0;
            state <= HOME_WAIT_HIGH;
          end
          HOME_WAIT_HIGH: begin
            timer <= '0;
            state <= DONE;
          end
          DONE: begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mmcm_phase_sweep.sv
// Scoreboard bench for mmcm_phase_sweep: the driver queues expected configure,
// point and done events, and a negedge monitor pops and compares them.
module tb_mmcm_phase_sweep;

  localparam int PW     = 32;
  localparam int CW     = 16;
  localparam int DW     = 16;
  localparam int TO     = 16;
  localparam int SETTLE = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [PW-1:0] start_phase;
  logic [PW-1:0] step;
  logic [CW-1:0] num_points;
  logic [DW-1:0] dwell_cycles;
  logic          return_home;
  logic          busy;
  logic          done;
  logic          error;
  logic          point_valid;
  logic [CW-1:0] point_index;
  logic [PW-1:0] ps_target;
  logic          ps_configure;
  logic          ps_configured;

  mmcm_phase_sweep #(
    .PHASE_WIDTH(PW), .COUNT_WIDTH(CW), .DWELL_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .start_phase(start_phase), .step(step), .num_points(num_points),
    .dwell_cycles(dwell_cycles), .return_home(return_home),
    .busy(busy), .done(done), .error(error), .point_valid(point_valid),
    .point_index(point_index), .ps_target(ps_target),
    .ps_configure(ps_configure), .ps_configured(ps_configured)
  );

  always #5 clk = ~clk;

  // Stepper model: configured drops the edge after configure and stays low SETTLE cycles.
  logic stuck = 1'b0;
  int   sc;
  logic cfg_at_edge;
  always @(posedge clk) begin
    cfg_at_edge <= ps_configured;
    if (rst) begin
      ps_configured <= 1'b1;
      sc            <= 0;
    end else if (stuck) begin
      ps_configured <= 1'b1;
    end else if (sc > 0) begin
      sc <= sc - 1;
      if (sc == 1) ps_configured <= 1'b1;
    end else if (ps_configure) begin
      ps_configured <= 1'b0;
      sc            <= SETTLE;
    end
  end

  typedef struct {
    int            idx;
    logic [PW-1:0] tgt;
  } pv_t;

  logic [PW-1:0] cfg_q[$];
  pv_t           pv_q[$];
  int            done_q[$];
  int            checks = 0;
  int            passes = 0;
  int            exp_gap = 0;

  function automatic void chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endfunction

  // Monitor
  initial begin
    int  cyc;
    int  last_pv;
    bit  pv_pending;
    logic [PW-1:0] e;
    pv_t p;
    cyc = 0; last_pv = 0; pv_pending = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) continue;
      if (ps_configure) begin
        chk("cfg_while_settled", cfg_at_edge, 1);
        if (pv_pending) chk("dwell_gap_cfg", cyc - last_pv, exp_gap);
        pv_pending = 0;
        if (cfg_q.size() == 0) chk("cfg_unexpected", cfg_q.size(), 1);
        else begin
          e = cfg_q.pop_front();
          $display("cfg   : target=0x%08h expected=0x%08h", ps_target, e);
          chk("cfg_target", ps_target, e);
        end
      end
      if (point_valid) begin
        if (pv_q.size() == 0) chk("pv_unexpected", pv_q.size(), 1);
        else begin
          p = pv_q.pop_front();
          $display("point : index=%0d target=0x%08h expected index=%0d target=0x%08h",
                   point_index, ps_target, p.idx, p.tgt);
          chk("pv_index", point_index, p.idx);
          chk("pv_target", ps_target, p.tgt);
        end
        last_pv = cyc;
        pv_pending = 1;
      end
      if (done) begin
        if (pv_pending) chk("dwell_gap_done", cyc - last_pv, exp_gap);
        pv_pending = 0;
        if (done_q.size() == 0) chk("done_unexpected", done_q.size(), 1);
        else begin
          void'(done_q.pop_front());
          $display("done  : busy=%0d error=%0d", busy, error);
          chk("done_busy_low", busy, 0);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_empty();
    chk("cfg_q_empty", cfg_q.size(), 0);
    chk("pv_q_empty", pv_q.size(), 0);
    chk("done_q_empty", done_q.size(), 0);
  endtask

  task automatic run_sweep(input logic [PW-1:0] sp, input logic [PW-1:0] st,
                           input int n, input int dw, input bit rh, output int t);
    logic [PW-1:0] tg;
    pv_t p;
    exp_gap = ((dw == 0) ? 1 : dw) + 2;
    tg = sp;
    for (int i = 0; i < n; i++) begin
      cfg_q.push_back(tg);
      p.idx = i;
      p.tgt = tg;
      pv_q.push_back(p);
      tg = tg + st;
    end
    if (rh && n > 0) cfg_q.push_back(sp);
    done_q.push_back(1);
    start_phase  = sp;
    step         = st;
    num_points   = CW'(n);
    dwell_cycles = DW'(dw);
    return_home  = rh;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    t = 0;
    while (busy && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("sweep_finished", busy, 0);
    tick(3);
    check_empty();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  t;
    pv_t p;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    start_phase = '0; step = '0; num_points = '0; dwell_cycles = '0; return_home = 1'b0;
    tick(3);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_point_valid", point_valid, 0);
    chk("rst_point_index", point_index, 0);
    chk("rst_ps_target", ps_target, 0);
    chk("rst_ps_configure", ps_configure, 0);
    rst = 1'b0;
    tick(2);

    // Basic three-point sweep
    run_sweep(32'd100, 32'd5, 3, 4, 1'b0, t);
    // Wrap-around in both directions
    run_sweep(32'h7FFF_FFFF, 32'hFFFF_FFFF, 2, 2, 1'b0, t);
    run_sweep(32'h7FFF_FFFF, 32'd2, 2, 1, 1'b0, t);
    // Empty sweep: done two cycles after start, no configure
    run_sweep(32'd77, 32'd1, 0, 4, 1'b0, t);
    chk("empty_done_latency", t, 1);
    // Return home
    run_sweep(32'd40, 32'd8, 2, 3, 1'b1, t);

    // Abort mid-move, then restart while the stepper is still settling
    cfg_q.push_back(32'd500);
    start_phase = 32'd500; step = 32'd1; num_points = 16'd2; dwell_cycles = 16'd2; return_home = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!ps_configure && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("abort_cfg_seen", ps_configure, 1);
    tick(3);
    chk("abort_stepper_busy", ps_configured, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy_low", busy, 0);
    chk("abort_target_hold", ps_target, 32'd500);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_same_cycle", busy, 0);
    chk("restart_stepper_busy", ps_configured, 0);
    run_sweep(32'd700, 32'd3, 1, 0, 1'b0, t);

    // Stepper that never drops configured: timeout after 16 cycles in WAIT_LOW
    stuck = 1'b1;
    cfg_q.push_back(32'd9);
    start_phase = 32'd9; step = 32'd1; num_points = 16'd1; dwell_cycles = 16'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!ps_configure && t < 50) begin
      @(negedge clk);
      t++;
    end
    t = 0;
    while (!error && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("timeout_cycles", t, TO);
    chk("timeout_error", error, 1);
    chk("timeout_busy_low", busy, 0);
    tick(3);
    check_empty();
    stuck = 1'b0;
    tick(2);
    run_sweep(32'd1, 32'd1, 1, 1, 1'b0, t);
    chk("error_cleared_by_start", error, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
